// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the MaxNet winner-take-all stage.
package maxnet_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // Accumulator width that holds the sum of m non-negative dw-bit values.
  function automatic int acc_w(input int dw, input int m);
    return dw + $clog2(m);
  endfunction

  // Clamp a signed value at zero (ReLU). Callers sign-extend into 64 bits and truncate back.
  function automatic logic signed [63:0] clamp0(input logic signed [63:0] v);
    return v[63] ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/maxnet_argmax.sv
// Combinational argmax over M signed elements with lowest-index tie-break, plus positive count.
module maxnet_argmax #(
  parameter int M      = 9,
  parameter int DATA_W = 16,
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1,
  localparam int PC_W  = $clog2(M + 1)
) (
  input  logic [M-1:0][DATA_W-1:0] x,
  output logic [IDX_W-1:0]         idx,
  output logic [DATA_W-1:0]        val,
  output logic [PC_W-1:0]          pos_cnt
);

  always_comb begin
    idx     = '0;
    val     = x[0];
    pos_cnt = '0;
    for (int i = 0; i < M; i++) begin
      // Strict compare keeps the earliest index on equal values.
      if ($signed(x[i]) > $signed(val)) begin
        val = x[i];
        idx = IDX_W'(i);
      end
      if ($signed(x[i]) > 0) pos_cnt = pos_cnt + PC_W'(1);
    end
  end

endmodule

// File: rtl/maxnet_winner.sv
// MaxNet lateral inhibition over the convolution result map; reports the surviving element.
module maxnet_winner
  import maxnet_pkg::*;
#(
  parameter int N         = 5,
  parameter int K         = 3,
  parameter int DATA_W    = 16,
  parameter int EPS_SHIFT = 4,
  parameter int MAX_ITER  = 64,
  localparam int R        = N - K + 1,
  localparam int RC_W     = (R > 1) ? $clog2(R) : 1,
  localparam int IT_W     = $clog2(MAX_ITER + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [R-1:0][R-1:0][DATA_W-1:0]  data,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [RC_W-1:0]                  winner_row,
  output logic [RC_W-1:0]                  winner_col,
  output logic [DATA_W-1:0]                winner_val,
  output logic [IT_W-1:0]                  iterations,
  output logic                             tie
);

  localparam int M     = R * R;
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int PC_W  = $clog2(M + 1);
  localparam int ACC_W = acc_w(DATA_W, M);

  // Inhibition must stay below 1/(M-1) or a single step can wipe out every element.
  if ((1 << EPS_SHIFT) <= M - 1) begin : g_eps_check
    $error("maxnet_winner: 2^EPS_SHIFT must exceed M-1");
  end

  state_t                  state_q, state_d;
  logic [M-1:0][DATA_W-1:0] x_q, x_d, x_ld, x_nxt;
  logic [IT_W-1:0]         iter_q, iter_d;
  logic [RC_W-1:0]         row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0]       val_q, val_d;
  logic [IT_W-1:0]         its_q, its_d;
  logic                    tie_q, tie_d;

  logic [IDX_W-1:0]        am_idx;
  logic [DATA_W-1:0]       am_val;
  logic [PC_W-1:0]         am_pos;
  logic [IDX_W-1:0]        am_row, am_col;
  logic [ACC_W-1:0]        sum;

  maxnet_argmax #(.M(M), .DATA_W(DATA_W)) u_argmax (
    .x       (x_q),
    .idx     (am_idx),
    .val     (am_val),
    .pos_cnt (am_pos)
  );

  assign am_row = IDX_W'(am_idx / IDX_W'(R));
  assign am_col = IDX_W'(am_idx % IDX_W'(R));

  for (genvar r = 0; r < R; r++) begin : g_row
    for (genvar c = 0; c < R; c++) begin : g_col
      assign x_ld[r*R+c] = DATA_W'(clamp0(64'($signed(data[r][c]))));
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) sum = sum + ACC_W'(x_q[i]);
  end

  // x[] is never negative, so S - x[i] cannot underflow; only the subtraction needs the sign bit.
  for (genvar i = 0; i < M; i++) begin : g_lane
    logic [ACC_W-1:0]   xi, oth;
    logic signed [ACC_W:0] upd;
    assign xi       = ACC_W'(x_q[i]);
    assign oth      = (sum - xi) >> EPS_SHIFT;
    assign upd      = $signed({1'b0, xi}) - $signed({1'b0, oth});
    assign x_nxt[i] = DATA_W'(clamp0(64'(upd)));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    iter_d  = iter_q;
    row_d   = row_q;
    col_d   = col_q;
    val_d   = val_q;
    its_d   = its_q;
    tie_d   = tie_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        x_d     = x_ld;
        iter_d  = '0;
        state_d = ITER;
      end
      ITER: begin
        if (am_pos <= PC_W'(1) || iter_q == IT_W'(MAX_ITER)) begin
          row_d   = am_row[RC_W-1:0];
          col_d   = am_col[RC_W-1:0];
          val_d   = am_val;
          its_d   = iter_q;
          tie_d   = (am_pos != PC_W'(1));
          state_d = DONE;
        end else begin
          x_d    = x_nxt;
          iter_d = iter_q + IT_W'(1);
        end
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      iter_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      its_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      iter_q  <= iter_d;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
      its_q   <= its_d;
      tie_q   <= tie_d;
    end
  end

  assign busy       = (state_q == LOAD) || (state_q == ITER);
  assign done       = (state_q == DONE);
  assign winner_row = row_q;
  assign winner_col = col_q;
  assign winner_val = val_q;
  assign iterations = its_q;
  assign tie        = tie_q;

endmodule
